// File: rtl/uart_rx_if.sv
// Bus bundle for uart_rx: oversample strobe and serial line in, received byte and status out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output baud_tick,
    output rx,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  baud_tick,
    input  rx,
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8x-oversampled UART receiver: LSB first, no parity, one stop bit.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote over the decision tick and the two before it.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int             BCW            = $clog2(DATA_BITS + 1);
  localparam logic [2:0]     START_DECISION = 3'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]     BIT_DECISION   = 3'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT       = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE        = BCW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic [1:0]           sync_r;
  logic                 rx_s;
  logic                 line_s;
  logic [2:0]           tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_done_r;
  logic                 frame_err_r;
  logic                 busy_r;
  logic                 armed_r;

  // Two-flop synchronizer on the asynchronous serial line; resets to idle-high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.rx};
    end
  end

  assign rx_s = sync_r[1];

`ifdef RX_MAJORITY_VOTE_EN
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] hist_r;

  // Last two tick samples of rx_s, feeding the vote at each decision tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_r <= 2'b11;
    end else if (bus.baud_tick) begin
      hist_r <= {hist_r[0], rx_s};
    end
  end

  assign line_s = majority3(hist_r[1], hist_r[0], rx_s);
`else
  assign line_s = rx_s;
`endif

  // Receive FSM: only baud ticks advance it; status pulses last one clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tick_cnt    <= 3'd0;
      bit_cnt     <= '0;
      shift_r     <= '0;
      rx_data_r   <= '0;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      if (bus.baud_tick) begin
        // A frame error below overrides this re-arm, so a held break cannot restart
        if (rx_s) begin
          armed_r <= 1'b1;
        end
        case (state_r)
          IDLE: begin
            tick_cnt <= 3'd0;
            bit_cnt  <= '0;
            if (!rx_s && armed_r) begin
              state_r <= START;
              busy_r  <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == START_DECISION) begin
              tick_cnt <= 3'd0;
              bit_cnt  <= '0;
              if (line_s) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 3'd1;
            end
          end
          DATA: begin
            tick_cnt <= tick_cnt + 3'd1;
            if (tick_cnt == BIT_DECISION) begin
              shift_r <= {line_s, shift_r[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BIT_ONE;
              if (bit_cnt == LAST_BIT) begin
                state_r <= STOP;
              end
            end
          end
          STOP: begin
            if (tick_cnt == BIT_DECISION) begin
              tick_cnt <= 3'd0;
              state_r  <= IDLE;
              busy_r   <= 1'b0;
              if (line_s) begin
                rx_data_r <= shift_r;
                rx_done_r <= 1'b1;
              end else begin
                frame_err_r <= 1'b1;
                armed_r     <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 3'd1;
            end
          end
          default: begin
            state_r  <= IDLE;
            tick_cnt <= 3'd0;
            bit_cnt  <= '0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_done   = rx_done_r;
  assign bus.frame_err = frame_err_r;
  assign bus.rx_busy   = busy_r;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 8, meaning baud_tick pulses per bit period; only the value 8 is supported.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; frames are LSB first, no parity, 1 stop bit.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port baud_tick  input  1  single-cycle oversample strobe from the baud generator at 8x the bit rate.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last correctly framed byte.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse marking that rx_data has been updated.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse marking a low stop bit.
REQ-010 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, with tick counter tick_cnt (3 bits) and bit counter bit_cnt.
REQ-013 SHALL advance the FSM, tick_cnt, and all sampling only on clk edges where baud_tick=1; with no ticks, all state SHALL hold.
REQ-014 In IDLE, rx_s=0 on a tick with the armed flag set SHALL move to START with tick_cnt=0.
REQ-015 The armed flag SHALL set on any tick with rx_s=1 and SHALL clear on frame error, so a held-low line (break) never restarts reception.
REQ-016 In START, the tick with tick_cnt==3 SHALL be the start decision point: line high -> IDLE (false start, no outputs); line low -> DATA with tick_cnt=0, bit_cnt=0.
REQ-017 In DATA, the tick with tick_cnt==7 SHALL sample one bit into shift register bit position DATA_BITS-1, shift right, increment bit_cnt, and wrap tick_cnt to 0.
REQ-018 After sampling bit DATA_BITS-1, the FSM SHALL move to STOP.
REQ-019 In STOP, the tick with tick_cnt==7 SHALL sample the stop bit and then move to IDLE.
REQ-020 A high stop bit SHALL load rx_data from the shift register and pulse rx_done.
REQ-021 A low stop bit SHALL pulse frame_err, leave rx_data unchanged, and clear the armed flag.
REQ-022 rx_done and frame_err SHALL be registered and asserted exactly one clk after the deciding tick edge; they SHALL never assert together.
REQ-023 rx_data SHALL hold its value until the next valid frame completes.
REQ-024 A new start bit SHALL be accepted on the first tick after the return to IDLE, supporting back-to-back frames.
REQ-025 Latency from the stop-bit decision tick to rx_done SHALL be 1 clk; the rx edge to rx_s delay is 2 clk.

Reset
REQ-026 While rst=0, the module SHALL go to IDLE with rx_data=0, rx_done=0, frame_err=0, rx_busy=0, tick_cnt=0, bit_cnt=0, synchronizer flops=1, armed=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no rx_done or frame_err pulse.
REQ-028 After reset release, one tick with rx_s=1 SHALL be required before a start is accepted.

Configuration
REQ-029 With macro RX_MAJORITY_VOTE_EN defined, each decision (start check, data bit, stop bit) SHALL use the 2-of-3 majority of rx_s sampled on ticks tick_cnt==decision-2, decision-1, and decision.
REQ-030 Without RX_MAJORITY_VOTE_EN, each decision SHALL use the single rx_s sample on the decision tick.

Verification (baud_tick every 1302 clk; bit period = 8 ticks)
REQ-031 Bench SHALL send 0xA5 with a valid stop bit -> one rx_done pulse 1 clk after the stop decision tick, rx_data=0xA5, no frame_err.
REQ-032 Bench SHALL drive rx low for 2 ticks, then high -> FSM returns to IDLE, and no rx_done or frame_err occurs.
REQ-033 Bench SHALL send 0x3C with a low stop bit, then hold rx low for 40 ticks -> exactly one frame_err, rx_data keeps its prior value, and no restart until rx goes high.
REQ-034 Bench SHALL send 0x00 then 0xFF back-to-back with no idle gap -> two rx_done pulses, with rx_data=0x00 then 0xFF.
REQ-035 Bench SHALL assert rst mid-DATA of 0x55 -> no pulses, all outputs 0; a subsequent 0x81 is received correctly.
REQ-036 With RX_MAJORITY_VOTE_EN, bench SHALL send 0xF0 with bit 2 inverted for only the decision tick -> rx_data=0xF0; without the macro, rx_data=0xF4.
